// File: rtl/shift_pkg.sv
// Types and direction encodings shared by the PISO transmitter and the SIPO receiver.
package shift_pkg;

  typedef enum logic {IDLE, SHIFT} tx_state_t;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry word+dir holding register: push fills it, pop empties it,
// and a full entry is never overwritten.
module piso_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_dir,
  input  logic             pop,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             dir
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;
  logic             dir_r;

  // Entry storage and occupancy flag; pop takes priority over a push.
  always_ff @(posedge clk) begin
    if (!res) begin
      full_r <= 1'b0;
      data_r <= {WIDTH{1'b0}};
      dir_r  <= 1'b0;
    end else if (pop) begin
      full_r <= 1'b0;
    end else if (push && !full_r) begin
      full_r <= 1'b1;
      data_r <= push_data;
      dir_r  <= push_dir;
    end
  end

  assign full = full_r;
  assign data = data_r;
  assign dir  = dir_r;

endmodule

// File: rtl/piso_shift_tx.sv
// Bidirectional parallel-in serial-out transmitter with a one-word holding
// register so consecutive words stream without an idle cycle.
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  tx_state_t        state_r;
  tx_state_t        state_s;
  logic [WIDTH-1:0] shifter_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;

  logic             hold_full_s;
  logic [WIDTH-1:0] hold_data_s;
  logic             hold_dir_s;

  logic             ready_s;
  logic             accept_s;
  logic             last_s;
  logic             push_s;
  logic             pop_s;
  logic             load_s;
  logic [WIDTH-1:0] load_data_s;
  logic             load_dir_s;

  assign ready_s  = res & ~hold_full_s;
  assign accept_s = in_valid & ready_s;
  assign last_s   = (state_r == SHIFT) && (cnt_r == CNT_W'(WIDTH - 1));

  // A word arriving on the last bit with the hold register empty goes
  // straight to the shifter; otherwise a mid-word arrival is parked.
  assign push_s      = accept_s & (state_r == SHIFT) & ~last_s;
  assign pop_s       = last_s & hold_full_s;
  assign load_s      = pop_s | (accept_s & ~push_s);
  assign load_data_s = pop_s ? hold_data_s : in_data;
  assign load_dir_s  = pop_s ? hold_dir_s  : in_dir;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .res       (res),
    .push      (push_s),
    .push_data (in_data),
    .push_dir  (in_dir),
    .pop       (pop_s),
    .full      (hold_full_s),
    .data      (hold_data_s),
    .dir       (hold_dir_s)
  );

  // State register plus shifter, word direction and bit counter.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_r   <= IDLE;
      shifter_r <= {WIDTH{1'b0}};
      dir_r     <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (load_s) begin
        shifter_r <= load_data_s;
        dir_r     <= load_dir_s;
        cnt_r     <= {CNT_W{1'b0}};
      end else if (state_r == SHIFT) begin
        if (dir_r == DIR_MSB_FIRST) begin
          shifter_r <= {shifter_r[WIDTH-2:0], 1'b0};
        end else begin
          shifter_r <= {1'b0, shifter_r[WIDTH-1:1]};
        end
        cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = SHIFT;
        else          state_s = IDLE;
      end
      SHIFT: begin
        if (last_s && !hold_full_s && !accept_s) state_s = IDLE;
        else                                     state_s = SHIFT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Serial outputs decoded purely from registered state.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    case (state_r)
      IDLE: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
      end
      SHIFT: begin
        sout       = (dir_r == DIR_MSB_FIRST) ? shifter_r[WIDTH-1] : shifter_r[0];
        sout_valid = 1'b1;
        sout_last  = last_s;
      end
      default: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
      end
    endcase
  end

  assign in_ready = ready_s;
  assign busy     = (state_r == SHIFT) | hold_full_s;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: reset, both bit orders, back-to-back
// streaming with stall, mid-word reset, and loopback into a SIPO model.
module tb_piso_shift_tx;

  logic       clk;
  logic       res;
  logic [7:0] in_data;
  logic       in_dir;
  logic       in_valid;
  logic       in_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_last;
  logic       busy;

  int n_cmp;
  int n_err;

  piso_shift_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .res        (res),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single word; exp_seq[7] is the first bit expected on sout.
  task automatic send_single(input logic [7:0] data, input logic dir, input logic [7:0] exp_seq);
    in_data  = data;
    in_dir   = dir;
    in_valid = 1'b1;
    check_val("single_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_dir   = ~dir;
    in_data  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check_val("single_sout",  32'(sout),       32'(exp_seq[7-i]));
      check_val("single_valid", 32'(sout_valid), 32'd1);
      check_val("single_last",  32'(sout_last),  32'(i == 7));
      tick();
    end
    check_val("single_end_valid", 32'(sout_valid), 32'd0);
    check_val("single_end_busy",  32'(busy),       32'd0);
    check_val("single_end_sout",  32'(sout),       32'd0);
  endtask

  initial begin
    logic [15:0] b2b_seq;
    logic [7:0]  rx;
    logic [7:0]  w;
    logic        d;

    n_cmp    = 0;
    n_err    = 0;
    res      = 1'b0;
    in_data  = 8'h00;
    in_dir   = 1'b0;
    in_valid = 1'b0;

    // Reset
    tick(); tick(); tick();
    check_val("rst_ready_low", 32'(in_ready),   32'd0);
    check_val("rst_valid",     32'(sout_valid), 32'd0);
    check_val("rst_busy",      32'(busy),       32'd0);
    check_val("rst_sout",      32'(sout),       32'd0);
    res = 1'b1;
    tick();
    check_val("post_rst_sout",  32'(sout),       32'd0);
    check_val("post_rst_valid", 32'(sout_valid), 32'd0);
    check_val("post_rst_busy",  32'(busy),       32'd0);
    check_val("post_rst_ready", 32'(in_ready),   32'd1);

    // 8'h1E both ways
    send_single(8'h1E, 1'b1, 8'b0001_1110);
    send_single(8'h1E, 1'b0, 8'b0111_1000);

    // Back-to-back F0 (MSB-first) then 0F (LSB-first)
    b2b_seq  = 16'b1111_0000_1111_0000;
    in_data  = 8'hF0;
    in_dir   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_val("b2b_sout",  32'(sout),       32'(b2b_seq[15-i]));
      check_val("b2b_valid", 32'(sout_valid), 32'd1);
      check_val("b2b_last",  32'(sout_last),  32'((i == 7) || (i == 15)));
      check_val("b2b_ready", 32'(in_ready),   32'((i == 0) || (i >= 8)));
      check_val("b2b_busy",  32'(busy),       32'd1);
      if (i == 0) begin
        in_data  = 8'h0F;
        in_dir   = 1'b0;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
    end
    check_val("b2b_end_valid", 32'(sout_valid), 32'd0);
    check_val("b2b_end_busy",  32'(busy),       32'd0);

    // Reset while shifting 8'hAA with 8'h55 held
    in_data  = 8'hAA;
    in_dir   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h55;
    in_dir   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_val("mid_bit4_sout", 32'(sout), 32'd1);
    check_val("mid_hold_busy", 32'(busy), 32'd1);
    res = 1'b0;
    tick();
    check_val("mid_rst_valid", 32'(sout_valid), 32'd0);
    check_val("mid_rst_busy",  32'(busy),       32'd0);
    check_val("mid_rst_ready", 32'(in_ready),   32'd0);
    res = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("mid_after_valid", 32'(sout_valid), 32'd0);
    end
    check_val("mid_after_busy", 32'(busy), 32'd0);

    // Loopback into a SIPO receiver model
    rx = 8'h00;
    for (int k = 0; k < 4; k++) begin
      w        = 8'($urandom_range(255, 0));
      d        = (k % 2) == 0;
      in_data  = w;
      in_dir   = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (sout_valid) begin
          if (d) rx = {rx[6:0], sout};
          else   rx = {sout, rx[7:1]};
        end
        tick();
      end
      check_val("loopback_word", 32'(rx), 32'(w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- WIDTH-bit bidirectional parallel-in serial-out transmitter. It is the transmit-side counterpart of the team's 8-bit bidirectional SIPO shift register.
- Accepts parallel words over a valid/ready handshake and serializes them one bit per clock, MSB-first or LSB-first per word.
- A one-entry holding register lets consecutive words stream with no idle cycle between them.
- sout/dir convention matches the SIPO receiver: driving sout into its serial input with the same dir reconstructs the word on its parallel output.

Parameters:
- WIDTH, 8, word length in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  clock, all logic on rising edge
- res  in  1  reset, synchronous, active-low
- in_data  in  WIDTH  parallel word to transmit
- in_dir  in  1  1 = MSB-first, 0 = LSB-first; captured with the word
- in_valid  in  1  in_data/in_dir are valid
- in_ready  out  1  block can accept a word this cycle
- sout  out  1  serial data bit
- sout_valid  out  1  sout carries a word bit this cycle
- sout_last  out  1  final bit of current word
- busy  out  1  shifting or holding register occupied

Behaviour:
- Reset (res low at a rising edge):
  - sout=0, sout_valid=0, sout_last=0, busy=0; hold register empty; state IDLE; bit counter 0.
  - in_ready is 0 while res is low.
  - Reset mid-word aborts the word and discards any held word. There is no partial completion.
- Accept: a transfer occurs at a rising edge when in_valid and in_ready are both 1. in_ready = res & !hold_full.
- States:
  - IDLE: sout_valid=0, sout=0.
  - SHIFT: one bit per cycle for WIDTH cycles.
- IDLE plus accept: the word loads the shifter and the state moves to SHIFT. The first bit appears on sout with sout_valid=1 in the next cycle, giving latency 1.
- SHIFT bit order:
  - dir=1 sends shifter[WIDTH-1] first, shifting left and filling with 0.
  - dir=0 sends shifter[0] first, shifting right and filling with 0.
  - Each bit is held exactly one cycle.
- Counter: counts bits sent, 0..WIDTH-1. sout_last=1 when counter=WIDTH-1.
- Accept during SHIFT, not last bit: the word goes to the hold register and hold_full becomes 1.
- End of word (cycle with sout_last=1):
  - If hold is full: the held word loads the shifter, hold_full clears, and the first bit of the new word appears next cycle with no gap.
  - Otherwise, if an accept happens that same cycle: the incoming word loads the shifter directly with no gap.
  - Otherwise the state returns to IDLE.
- Hold full: in_ready=0, so new words stall upstream. The held word and its dir are never overwritten.
- dir is per word. Changing in_dir outside an accepting edge has no effect.
- in_data is ignored unless a transfer occurs.
- busy = (state==SHIFT) | hold_full.

Decomposition:
- Shared package shift_pkg holds:
  - typedef enum {IDLE, SHIFT} tx_state_t
  - localparams DIR_MSB_FIRST=1 and DIR_LSB_FIRST=0, shared with the SIPO receiver
- One natural sub-module, piso_hold_buf: the one-entry word+dir holding register with full flag, push/pop, and synchronous active-low clear.
- The counter, state machine and shifter live in the top module.

Test Plan:
- Reset check: hold res=0 for 3 cycles, then release with in_valid=0 -> sout=0, sout_valid=0, busy=0, in_ready=1 after release.
- MSB-first: in_data=8'h1E, in_dir=1, single accept -> sout 0,0,0,1,1,1,1,0 on 8 consecutive cycles starting 1 cycle after accept; sout_last on 8th only; then IDLE.
- LSB-first: in_data=8'h1E, in_dir=0 -> sout 0,1,1,1,1,0,0,0; sout_valid high for exactly 8 cycles.
- Back-to-back with mixed dir:
  - Stimulus: accept 8'hF0 (dir=1), then 8'h0F (dir=0) while the first word is shifting.
  - Response: 16 consecutive valid cycles, sout = 1,1,1,1,0,0,0,0, 1,1,1,1,0,0,0,0; sout_last at cycles 8 and 16.
  - Stall check: in_ready=0 from accepting the second word until its transfer into the shifter at the end of the first word.
- Reset mid-operation: assert res=0 on bit 4 of 8'hAA with 8'h55 held -> next cycle sout_valid=0, busy=0; after release no bits from either word appear.
- Loopback: feed sout into the SIPO receiver, gated on sout_valid, with matching dir, for random words in both directions -> receiver parallel output equals the sent word after 8 bits.
